// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register file write-port arbiter.
// Default geometry matches the 32x32 register file Registro2.
package regfile_pkg;

   localparam int NREGS = 32;
   localparam int DW    = 32;
   localparam int AW    = $clog2(NREGS);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          we;
   } wr_cmd_t;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-input round-robin arbiter with a single priority flop.
// Priority passes to the other port after every grant.
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic prio_q;
   logic prio_d;

   // lone requester wins; a tie goes to the port holding priority
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
         end else begin
            gnt_o = req_i;
         end
      end
   end

   // hand priority to the port that did not just win
   always_comb begin
      prio_d = prio_q;
      if (gnt_o[0]) begin
         prio_d = 1'b1;
      end else if (gnt_o[1]) begin
         prio_d = 1'b0;
      end
   end

   // priority register, port 0 first out of reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port: round-robin writeback
// arbitration plus a zero-fill clear sweep, all from registered outputs.
module regfile_write_arbiter #(
   parameter  int NREGS       = 32,
   parameter  int DW          = 32,
   parameter  int ZERO_REG_RO = 1,
   localparam int AW          = $clog2(NREGS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wb0_valid,
   input  logic [AW-1:0] wb0_addr,
   input  logic [DW-1:0] wb0_data,
   output logic          wb0_ready,
   input  logic          wb1_valid,
   input  logic [AW-1:0] wb1_addr,
   input  logic [DW-1:0] wb1_data,
   output logic          wb1_ready,
   input  logic          clr_start,
   output logic          clr_busy,
   output logic          clr_done,
   output logic [AW-1:0] rf_A3,
   output logic [DW-1:0] rf_WR3,
   output logic          rf_writeRegister
);

   import regfile_pkg::*;

   localparam logic [AW-1:0] FIRST = (ZERO_REG_RO != 0) ? AW'(1) : AW'(0);
   localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
   localparam logic          RO0   = (ZERO_REG_RO != 0);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   wr_cmd_t       cmd_q, cmd_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          start;
   logic          arb_en;
   logic [1:0]    gnt;

   assign start  = (state_q == IDLE) && clr_start;
   assign arb_en = (state_q == IDLE) && !clr_start && !reset;

   rr_arbiter2 u_arb (
      .clk_i (clock),
      .rst_i (reset),
      .en_i  (arb_en),
      .req_i ({wb1_valid, wb0_valid}),
      .gnt_o (gnt)
   );

   assign wb0_ready = gnt[0];
   assign wb1_ready = gnt[1];

   // state register and sweep counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state: a sweep walks the counter FIRST..LAST, never wrapping
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (clr_start) begin
               cnt_d   = FIRST;
               state_d = (FIRST == LAST) ? IDLE : CLEAR;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_d == LAST) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // next rf command: clear writes beat writebacks; reg 0 writes are dropped
   always_comb begin
      cmd_d    = cmd_q;
      cmd_d.we = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      if (start || (state_q == CLEAR)) begin
         cmd_d.addr = cnt_d;
         cmd_d.data = '0;
         cmd_d.we   = 1'b1;
         busy_d     = 1'b1;
         done_d     = (cnt_d == LAST);
      end else if (gnt[0]) begin
         cmd_d.addr = wb0_addr;
         cmd_d.data = wb0_data;
         cmd_d.we   = !(RO0 && (wb0_addr == '0));
      end else if (gnt[1]) begin
         cmd_d.addr = wb1_addr;
         cmd_d.data = wb1_data;
         cmd_d.we   = !(RO0 && (wb1_addr == '0));
      end
   end

   // registered write port and sweep flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cmd_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cmd_q  <= cmd_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign rf_A3            = cmd_q.addr;
   assign rf_WR3           = cmd_q.data;
   assign rf_writeRegister = cmd_q.we;
   assign clr_busy         = busy_q;
   assign clr_done         = done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: behavioural model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_regfile_write_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        wb0_valid, wb1_valid, clr_start;
   logic [4:0]  wb0_addr, wb1_addr;
   logic [31:0] wb0_data, wb1_data;
   logic        wb0_ready, wb1_ready, clr_busy, clr_done;
   logic [4:0]  rf_A3;
   logic [31:0] rf_WR3;
   logic        rf_writeRegister;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_write_arbiter dut (
      .clock            (clock),
      .reset            (reset),
      .wb0_valid        (wb0_valid),
      .wb0_addr         (wb0_addr),
      .wb0_data         (wb0_data),
      .wb0_ready        (wb0_ready),
      .wb1_valid        (wb1_valid),
      .wb1_addr         (wb1_addr),
      .wb1_data         (wb1_data),
      .wb1_ready        (wb1_ready),
      .clr_start        (clr_start),
      .clr_busy         (clr_busy),
      .clr_done         (clr_done),
      .rf_A3            (rf_A3),
      .rf_WR3           (rf_WR3),
      .rf_writeRegister (rf_writeRegister)
   );

   always #5 clock = ~clock;

   // model state: priority port, pending sweep addresses, expected outputs
   int          m_prio = 0;
   int          q_addr[$];
   int          glog[$];
   logic [4:0]  e_a = '0;
   logic [31:0] e_d = '0;
   logic        e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;
   logic [31:0] mem [32] = '{default: 32'd0};

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [1:0] m_grant();
      if (reset || q_addr.size() != 0 || clr_start) return 2'b00;
      if (wb0_valid && wb1_valid) return (m_prio == 0) ? 2'b01 : 2'b10;
      return {wb1_valid, wb0_valid};
   endfunction

   // reference model, advanced on each edge
   always @(posedge clock or posedge reset) begin
      logic [1:0] g;
      int a;
      if (reset) begin
         m_prio = 0;
         q_addr.delete();
         e_a = '0; e_d = '0;
         e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end else begin
         if (rf_writeRegister) mem[rf_A3] = rf_WR3;
         g = m_grant();
         e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         if (q_addr.size() > 0) begin
            a = q_addr.pop_front();
            e_a = 5'(a); e_d = '0; e_we = 1'b1;
            e_busy = 1'b1; e_done = (a == 31);
         end else if (clr_start) begin
            for (int i = 2; i < 32; i++) q_addr.push_back(i);
            e_a = 5'd1; e_d = '0; e_we = 1'b1; e_busy = 1'b1;
         end else if (g[0]) begin
            e_a = wb0_addr; e_d = wb0_data; e_we = (wb0_addr != 0);
            m_prio = 1; glog.push_back(0);
         end else if (g[1]) begin
            e_a = wb1_addr; e_d = wb1_data; e_we = (wb1_addr != 0);
            m_prio = 0; glog.push_back(1);
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clock) begin
      logic [1:0] g;
      g = m_grant();
      chk("m_wb0_ready", 32'(wb0_ready), 32'(g[0]));
      chk("m_wb1_ready", 32'(wb1_ready), 32'(g[1]));
      chk("m_rf_A3", 32'(rf_A3), 32'(e_a));
      chk("m_rf_WR3", rf_WR3, e_d);
      chk("m_rf_we", 32'(rf_writeRegister), 32'(e_we));
      chk("m_clr_busy", 32'(clr_busy), 32'(e_busy));
      chk("m_clr_done", 32'(clr_done), 32'(e_done));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int expg[4] = '{0, 1, 0, 1};
      int nz, nb, nd, nzr;
      logic g0, g1, done_seen, found;

      reset = 1'b1;
      wb0_valid = 0; wb1_valid = 0; clr_start = 0;
      wb0_addr = 0; wb1_addr = 0; wb0_data = 0; wb1_data = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk("rst_A3", 32'(rf_A3), 0);
      chk("rst_we", 32'(rf_writeRegister), 0);
      chk("rst_busy", 32'(clr_busy), 0);

      // single write from port 0
      wb0_valid = 1; wb0_addr = 5; wb0_data = 874;
      #1 chk("s_ready0", 32'(wb0_ready), 1);
      tick();
      wb0_valid = 0;
      #1;
      chk("s_A3", 32'(rf_A3), 5);
      chk("s_WR3", rf_WR3, 874);
      chk("s_we", 32'(rf_writeRegister), 1);
      tick();
      chk("s_rd5", mem[5], 874);
      chk("s_we_off", 32'(rf_writeRegister), 0);
      chk("s_hold", 32'(rf_A3), 5);

      // write to register 0 is accepted but dropped
      wb1_valid = 1; wb1_addr = 0; wb1_data = 8;
      #1 chk("z_ready1", 32'(wb1_ready), 1);
      tick();
      wb1_valid = 0;
      #1 chk("z_we", 32'(rf_writeRegister), 0);
      tick();
      chk("z_rd0", mem[0], 0);

      // contention: grants alternate starting at port 0
      glog.delete();
      wb0_valid = 1; wb0_addr = 3; wb0_data = 111;
      wb1_valid = 1; wb1_addr = 20; wb1_data = 83948;
      for (int k = 0; k < 4; k++) begin
         #1;
         g0 = wb0_ready; g1 = wb1_ready;
         tick();
         if (g0) begin wb0_addr = 4; wb0_data = 222; end
         if (g1) begin wb1_addr = 21; wb1_data = 83949; end
      end
      wb0_valid = 0; wb1_valid = 0;
      tick(); tick();
      chk("c_count", glog.size(), 4);
      for (int k = 0; k < 4 && k < glog.size(); k++)
         chk("c_grant", glog[k], expg[k]);
      chk("c_rd3", mem[3], 111);
      chk("c_rd20", mem[20], 83948);
      chk("c_rd4", mem[4], 222);
      chk("c_rd21", mem[21], 83949);

      // async reset mid-cycle with a write on the port
      wb0_valid = 1; wb0_addr = 9; wb0_data = 99;
      tick();
      #2 reset = 1'b1;
      #1;
      chk("r_we", 32'(rf_writeRegister), 0);
      chk("r_A3", 32'(rf_A3), 0);
      chk("r_WR3", rf_WR3, 0);
      chk("r_ready", 32'(wb0_ready), 0);
      tick();
      reset = 1'b0; wb0_valid = 0;
      chk("r_rd9", mem[9], 0);

      // clear sweep with both requesters waiting
      wb0_valid = 1; wb0_addr = 7; wb0_data = 77;
      wb1_valid = 1; wb1_addr = 8; wb1_data = 88;
      clr_start = 1;
      #1 chk("k_start_rdy", 32'({wb1_ready, wb0_ready}), 0);
      nz = 1; nb = 0; nd = 0; done_seen = 0;
      tick();
      clr_start = 0;
      for (int k = 0; k < 36; k++) begin
         #1;
         if (k == 0) chk("k_first_A3", 32'(rf_A3), 1);
         if (clr_busy) nb++;
         if (!done_seen && !wb0_ready && !wb1_ready) nz++;
         if (clr_done) begin
            nd++;
            done_seen = 1;
            chk("k_done_A3", 32'(rf_A3), 31);
            chk("k_done_gnt", 32'(wb0_ready), 1);
         end
         tick();
         if (done_seen) begin wb0_valid = 0; wb1_valid = 0; end
      end
      chk("k_done_seen", 32'(done_seen), 1);
      chk("k_done_n", nd, 1);
      chk("k_busy_n", nb, 31);
      chk("k_rdy0_n", nz, 31);
      nzr = 0;
      for (int i = 1; i < 32; i++)
         if (i != 7 && mem[i] != 0) nzr++;
      chk("k_zeroed", nzr, 0);
      chk("k_rd7", mem[7], 77);
      chk("k_busy_off", 32'(clr_busy), 0);

      // abort a sweep at its 10th write, then restart
      clr_start = 1;
      tick();
      clr_start = 0;
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         #1;
         if (rf_A3 == 5'd10) found = 1;
         else tick();
      end
      chk("a_found", 32'(found), 1);
      #1 reset = 1'b1;
      #1;
      chk("a_we", 32'(rf_writeRegister), 0);
      chk("a_A3", 32'(rf_A3), 0);
      chk("a_busy", 32'(clr_busy), 0);
      tick();
      reset = 1'b0;
      clr_start = 1;
      tick();
      clr_start = 0;
      #1;
      chk("a_restart_A3", 32'(rf_A3), 1);
      chk("a_restart_busy", 32'(clr_busy), 1);
      repeat (35) tick();
      chk("a_idle", 32'(clr_busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (A3/WR3/writeRegister) of the 32x32 register file `Registro2`.
- Arbitrates it round-robin between two writeback requesters (port 0: ALU writeback; port 1: load writeback) using a valid/ready handshake.
- Also runs a clear sequencer that writes zero to every writable register on command.
- Drives the register file write port from registered outputs, so the register file sees one clean write per cycle.

Parameters:
- NREGS, 32, number of registers; address width = $clog2(NREGS) = 5.
- DW, 32, data width.
- ZERO_REG_RO, 1, when 1: register 0 is never written; clear sweep starts at address 1.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb0_valid  in  1  requester 0 has a write pending.
- wb0_addr  in  5  requester 0 destination register.
- wb0_data  in  DW  requester 0 write data.
- wb0_ready  out  1  requester 0 write accepted this cycle (combinational).
- wb1_valid / wb1_addr / wb1_data / wb1_ready: same as port 0, for requester 1.
- clr_start  in  1  single-cycle request to start a clear sweep.
- clr_busy  out  1  high in every cycle the rf outputs carry a clear write.
- clr_done  out  1  high only in the cycle the final clear write (addr NREGS-1) is presented.
- rf_A3  out  5  register file write address (to A3).
- rf_WR3  out  DW  register file write data (to WR3).
- rf_writeRegister  out  1  register file write enable (to writeRegister).

Behaviour:
- Reset (async, immediate):
  - Every output register clears to 0: rf_A3, rf_WR3, rf_writeRegister, clr_busy, clr_done.
  - State = IDLE; round-robin priority = port 0; sweep counter = 0.
- States:
  - IDLE: arbitration active.
  - CLEAR: sweep active; both ready outputs are 0.
- Arbitration (IDLE, clr_start=0):
  - Only one valid → that port is granted.
  - Both valid → the port holding priority is granted.
  - wbN_ready = grant for port N; ready never asserts without the matching valid.
  - Transfer occurs when valid & ready are both high at the clock edge.
  - After any transfer, priority moves to the other port.
  - Requesters must hold addr/data stable while valid=1 and ready=0.
- Write latency:
  - A transfer accepted in cycle T appears on rf_* in cycle T+1 with rf_writeRegister=1.
  - The register file commits it at the end of T+1.
  - No transfer in T → rf_writeRegister=0 in T+1; rf_A3/rf_WR3 hold their last values.
- Register-0 filter: with ZERO_REG_RO=1, a write to addr 0 is still accepted (ready=1), but rf_writeRegister=0 in T+1.
- Clear start:
  - clr_start=1 in IDLE at cycle T wins over any wb request in the same cycle; both readies are 0.
  - At edge T: state → CLEAR; output regs load addr FIRST (1 if ZERO_REG_RO, else 0) with data 0, we=1, clr_busy=1.
- Clear sweep:
  - CLEAR issues one clear write per cycle with ascending addresses.
  - The edge that loads address NREGS-1 also sets clr_done=1 and returns state to IDLE.
  - wb requests can therefore be granted during the final clear cycle; their write lands the cycle after.
  - Clear write count: NREGS-FIRST (31 with defaults); clr_busy is high for exactly that many consecutive cycles.
  - clr_start while in CLEAR is ignored; no restart, no queuing.
- Reset mid-sweep: aborts immediately, all outputs 0; registers already cleared stay cleared.
- Counter/address arithmetic: 5-bit unsigned; the sweep terminates at NREGS-1 and never wraps.

Decomposition:
- Shared package regfile_pkg holds:
  - NREGS, DW, AW constants;
  - state enum {IDLE, CLEAR};
  - typedef for a write command struct {addr, data, we}.
- One sub-module is natural: rr_arbiter2 (2-input round-robin grant plus priority flop).
- The FSM, sweep counter and output registers stay in the top.

Test Plan:
- Reset: assert reset mid-cycle with wb0_valid=1 → all outputs 0 immediately (async), no ready while reset high.
- Single port: wb0 (addr 5, data 874) in cycle T → wb0_ready=1 in T; rf_A3=5, rf_WR3=874, rf_writeRegister=1 in T+1; read back R1 via A1=5 → 874.
- Contention: both valid for 4 cycles (wb0 addr 3/4, wb1 addr 20 data 83948, ...) → grants alternate 0,1,0,1; each requester gets exactly one write per two cycles.
- Register 0: wb1 addr 0, data 8 → wb1_ready=1, rf_writeRegister=0 next cycle; R at addr 0 stays 0.
- Clear: clr_start with both wb valid → readies 0 for 31 cycles; rf_A3 runs 1..31 with data 0; clr_done high only with addr 31; wb grant resumes in that same cycle.
- Abort: reset at the 10th sweep cycle → outputs 0, state IDLE; a fresh clr_start restarts at addr 1.
